ttl_univ_shift_reg: RTL and testbench



---
 rtl/ttl_univ_shift_reg_pkg.sv | 14 +
 rtl/ttl_univ_shift_reg_if.sv | 33 +++
 rtl/ttl_univ_shift_reg_sr_cell.sv | 62 ++++++
 rtl/ttl_univ_shift_reg.sv | 61 ++++++
 tb/tb_ttl_univ_shift_reg.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ttl_univ_shift_reg_pkg.sv
// Shared types for the TTL-equivalent shift register cells.
// Mode encoding matches the LS194 S1:S0 pins.
package ttl_pkg;

    typedef enum logic [1:0] {
        SR_HOLD = 2'b00,
        SR_SHR  = 2'b01,
        SR_SHL  = 2'b10,
        SR_LOAD = 2'b11
    } sr_mode_t;

    localparam int TTL_MAX_WIDTH = 32;

endpackage

// File: rtl/ttl_univ_shift_reg_if.sv
// Data/control bundle of the universal shift register.
// master drives mode, serial and parallel inputs; slave returns q and n_q.
interface ttl_univ_shift_reg_if #(
    parameter int WIDTH = 4
) ();
    import ttl_pkg::*;

    sr_mode_t           s;
    logic               sr_in;
    logic               sl_in;
    logic [WIDTH-1:0]   d;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   n_q;

    modport master (
        output s,
        output sr_in,
        output sl_in,
        output d,
        input  q,
        input  n_q
    );

    modport slave (
        input  s,
        input  sr_in,
        input  sl_in,
        input  d,
        output q,
        output n_q
    );

endinterface

// File: rtl/ttl_univ_shift_reg_sr_cell.sv
// One register bit: 4:1 mode mux into a flop with async clear (and preset with TTL_SR_PRESET_EN).
// Latency: one clk edge for synchronous modes, zero for async clear/preset.
// Backpressure: none; the bit updates on every enabled edge.
module ttl_sr_cell
    import ttl_pkg::*;
#(
    parameter logic CLR_BIT = 1'b0
) (
    input  logic     clk,
    input  logic     n_clr,
`ifdef TTL_SR_PRESET_EN
    input  logic     n_pre,
`endif
    input  sr_mode_t mode_i,
    input  logic     shr_i,
    input  logic     shl_i,
    input  logic     d_i,
    output logic     q_o
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q;
        case (mode_i)
            SR_HOLD: q_d = q_q;
            SR_SHR:  q_d = shr_i;
            SR_SHL:  q_d = shl_i;
            SR_LOAD: q_d = d_i;
            default: q_d = q_q;
        endcase
    end

`ifdef TTL_SR_PRESET_EN
    // Clear only acts while preset is idle, so releasing preset under a held
    // clear produces a fresh falling edge here and the flop reloads CLR_BIT.
    logic clr_only_n;
    assign clr_only_n = n_clr | ~n_pre;

    always_ff @(posedge clk or negedge clr_only_n or negedge n_pre) begin
        if (!n_pre) begin
            q_q <= 1'b1;
        end else if (!clr_only_n) begin
            q_q <= CLR_BIT;
        end else begin
            q_q <= q_d;
        end
    end
`else
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            q_q <= CLR_BIT;
        end else begin
            q_q <= q_d;
        end
    end
`endif

    assign q_o = q_q;

endmodule

// File: rtl/ttl_univ_shift_reg.sv
// WIDTH-bit LS194-style universal shift register (hold/shr/shl/load); optional preset via TTL_SR_PRESET_EN.
// Latency: one clk edge for synchronous modes, zero for async clear/preset.
// Backpressure: none; mode is applied on every enabled rising edge.
module ttl_univ_shift_reg
    import ttl_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic clk,
    input  logic n_clr,
`ifdef TTL_SR_PRESET_EN
    input  logic n_pre,
`endif
    ttl_univ_shift_reg_if.slave bus
);

    if (WIDTH < 1 || WIDTH > TTL_MAX_WIDTH) begin : g_width_chk
        $error("ttl_univ_shift_reg: WIDTH out of range 1..32");
    end

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] shr_src;
    logic [WIDTH-1:0] shl_src;

    // Value entering each bit for the two shift modes; no wrap-around.
    if (WIDTH == 1) begin : g_w1
        assign shr_src = bus.sr_in;
        assign shl_src = bus.sl_in;
    end else begin : g_wn
        assign shr_src = {q_w[WIDTH-2:0], bus.sr_in};
        assign shl_src = {bus.sl_in, q_w[WIDTH-1:1]};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ttl_sr_cell #(
            .CLR_BIT (CLR_VAL[i])
        ) u_cell (
            .clk    (clk),
            .n_clr  (n_clr),
`ifdef TTL_SR_PRESET_EN
            .n_pre  (n_pre),
`endif
            .mode_i (bus.s),
            .shr_i  (shr_src[i]),
            .shl_i  (shl_src[i]),
            .d_i    (bus.d[i]),
            .q_o    (q_w[i])
        );
    end

    assign bus.q = q_w;

`ifdef TTL_SR_PRESET_EN
    // Both async inputs low drives Q and nQ high together, as on the TTL part.
    assign bus.n_q = (!n_clr && !n_pre) ? '1 : ~q_w;
`else
    assign bus.n_q = ~q_w;
`endif

endmodule

// File: tb/tb_ttl_univ_shift_reg.sv
// Self-checking bench for ttl_univ_shift_reg: WIDTH=4/CLR=0 and WIDTH=1/CLR=1 instances.
// Preset checks are compiled when TTL_SR_PRESET_EN is defined.
module tb_ttl_univ_shift_reg;
    import ttl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_clr;
`ifdef TTL_SR_PRESET_EN
    logic n_pre;
`endif

    ttl_univ_shift_reg_if #(.WIDTH(4)) b4 ();
    ttl_univ_shift_reg_if #(.WIDTH(1)) b1 ();

    ttl_univ_shift_reg #(.WIDTH(4), .CLR_VAL(4'b0000)) dut4 (
        .clk   (clk),
        .n_clr (n_clr),
`ifdef TTL_SR_PRESET_EN
        .n_pre (n_pre),
`endif
        .bus   (b4)
    );

    ttl_univ_shift_reg #(.WIDTH(1), .CLR_VAL(1'b1)) dut1 (
        .clk   (clk),
        .n_clr (n_clr),
`ifdef TTL_SR_PRESET_EN
        .n_pre (n_pre),
`endif
        .bus   (b1)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] s;
        logic       sr;
        logic       sl;
        logic [3:0] d;
        logic [3:0] exp_q;
        string      nm;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk4(input string nm, input logic [3:0] eq, input logic [3:0] enq);
        chk({nm, "_q"}, 32'(b4.q), 32'(eq));
        chk({nm, "_nq"}, 32'(b4.n_q), 32'(enq));
    endtask

    task automatic chk1(input string nm, input logic eq, input logic enq);
        chk({nm, "_q1"}, 32'(b1.q), 32'(eq));
        chk({nm, "_nq1"}, 32'(b1.n_q), 32'(enq));
    endtask

    task automatic drive(input logic [1:0] s, input logic sr, input logic sl, input logic [3:0] d);
        b4.s     = sr_mode_t'(s);
        b4.sr_in = sr;
        b4.sl_in = sl;
        b4.d     = d;
        b1.s     = sr_mode_t'(s);
        b1.sr_in = sr;
        b1.sl_in = sl;
        b1.d     = d[0:0];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: register as a plain integer, modes as arithmetic on it.
    function automatic logic [31:0] mdl(input logic [31:0] q, input int w, input logic [1:0] s,
                                        input logic sr, input logic sl, input logic [31:0] d);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case (s)
            2'b00:   return q & mask;
            2'b01:   return ((q << 1) | 32'(sr)) & mask;
            2'b10:   return ((q & mask) >> 1) | (32'(sl) << (w - 1));
            default: return d & mask;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] m4;
        logic [31:0] m1;
        logic [1:0]  rs;
        logic        rsr;
        logic        rsl;
        logic [3:0]  rd;
        logic [3:0]  nexp;

        tbl[0]  = '{2'b11, 1'b0, 1'b0, 4'hA, 4'hA, "load_a"};
        tbl[1]  = '{2'b00, 1'b1, 1'b1, 4'h5, 4'hA, "hold1"};
        tbl[2]  = '{2'b00, 1'b0, 1'b1, 4'h3, 4'hA, "hold2"};
        tbl[3]  = '{2'b00, 1'b1, 1'b0, 4'hF, 4'hA, "hold3"};
        tbl[4]  = '{2'b11, 1'b0, 1'b0, 4'h0, 4'h0, "load_0"};
        tbl[5]  = '{2'b01, 1'b1, 1'b0, 4'h0, 4'h1, "shr1"};
        tbl[6]  = '{2'b01, 1'b1, 1'b0, 4'h0, 4'h3, "shr2"};
        tbl[7]  = '{2'b01, 1'b1, 1'b0, 4'h0, 4'h7, "shr3"};
        tbl[8]  = '{2'b01, 1'b1, 1'b0, 4'h0, 4'hF, "shr4"};
        tbl[9]  = '{2'b10, 1'b1, 1'b0, 4'h0, 4'h7, "shl1"};
        tbl[10] = '{2'b10, 1'b1, 1'b0, 4'h0, 4'h3, "shl2"};
        tbl[11] = '{2'b01, 1'b0, 1'b1, 4'h0, 4'h6, "shr_zero"};
        tbl[12] = '{2'b10, 1'b0, 1'b1, 4'h0, 4'hB, "shl_one"};

        // Reset state
        n_clr = 1'b0;
`ifdef TTL_SR_PRESET_EN
        n_pre = 1'b1;
`endif
        drive(2'b00, 1'b0, 1'b0, 4'h0);
        #12;
        chk4("reset", 4'h0, 4'hF);
        chk1("reset", 1'b1, 1'b0);
        n_clr = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].s, tbl[i].sr, tbl[i].sl, tbl[i].d);
            tick();
            nexp = ~tbl[i].exp_q;
            chk4(tbl[i].nm, tbl[i].exp_q, nexp);
        end

        // Async clear mid-cycle, edges ignored while low, first edge after release acts
        drive(2'b11, 1'b0, 1'b0, 4'hB);
        tick();
        chk4("pre_clr_load", 4'hB, 4'h4);
        #2 n_clr = 1'b0;
        #1;
        chk4("clr_mid", 4'h0, 4'hF);
        drive(2'b11, 1'b0, 1'b0, 4'hF);
        tick();
        chk4("clr_edge_ignored", 4'h0, 4'hF);
        n_clr = 1'b1;
        tick();
        chk4("clr_release_load", 4'hF, 4'h0);
        drive(2'b00, 1'b0, 1'b0, 4'h0);
        @(posedge clk);
        n_clr = 1'b0;
        #1;
        chk4("clr_at_edge", 4'h0, 4'hF);
        n_clr = 1'b1;

        // WIDTH=1 boundary
        #1 n_clr = 1'b0;
        #1;
        chk1("w1_reset", 1'b1, 1'b0);
        n_clr = 1'b1;
        drive(2'b01, 1'b0, 1'b1, 4'h0);
        tick();
        chk1("w1_shr", 1'b0, 1'b1);
        drive(2'b10, 1'b0, 1'b1, 4'h0);
        tick();
        chk1("w1_shl", 1'b1, 1'b0);

`ifdef TTL_SR_PRESET_EN
        drive(2'b00, 1'b0, 1'b0, 4'h0);
        #2 n_pre = 1'b0;
        #1;
        chk4("pre_only", 4'hF, 4'h0);
        chk1("pre_only", 1'b1, 1'b0);
        tick();
        chk4("pre_edge", 4'hF, 4'h0);
        n_clr = 1'b0;
        #1;
        chk4("pre_clr_both", 4'hF, 4'hF);
        n_pre = 1'b1;
        #1;
        chk4("pre_released_first", 4'h0, 4'hF);
        n_clr = 1'b1;
        #1;
        chk4("both_released_clr_last", 4'h0, 4'hF);
        tick();
        chk4("after_clr_last_hold", 4'h0, 4'hF);
        n_clr = 1'b0;
        #1 n_pre = 1'b0;
        #1 n_clr = 1'b1;
        #1;
        chk4("clr_released_first", 4'hF, 4'h0);
        n_pre = 1'b1;
        #1;
        chk4("both_released_pre_last", 4'hF, 4'h0);
        tick();
        n_clr = 1'b0;
        n_pre = 1'b0;
        #1;
        n_clr = 1'b1;
        n_pre = 1'b1;
        #1;
        chk4("simult_release", 4'hF, 4'h0);
        drive(2'b11, 1'b0, 1'b0, 4'h5);
        tick();
        chk4("post_preset_load", 4'h5, 4'hA);
`endif

        // Randomized run against the integer model
        #1 n_clr = 1'b0;
        #1 n_clr = 1'b1;
        m4 = 32'h0;
        m1 = 32'h1;
        for (int k = 0; k < 300; k++) begin
            rs  = 2'($urandom_range(0, 3));
            rsr = 1'($urandom_range(0, 1));
            rsl = 1'($urandom_range(0, 1));
            rd  = 4'($urandom_range(0, 15));
            drive(rs, rsr, rsl, rd);
            tick();
            m4 = mdl(m4, 4, rs, rsr, rsl, 32'(rd));
            m1 = mdl(m1, 1, rs, rsr, rsl, 32'(rd));
            chk("rnd_q4", 32'(b4.q), m4);
            chk("rnd_nq4", 32'(b4.n_q), (~m4) & 32'hF);
            chk("rnd_q1", 32'(b1.q), m1);
            if ($urandom_range(0, 15) == 0) begin
                #2 n_clr = 1'b0;
                #1;
                m4 = 32'h0;
                m1 = 32'h1;
                chk("rnd_clr_q4", 32'(b4.q), m4);
                chk("rnd_clr_q1", 32'(b1.q), m1);
                n_clr = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
